// File: rtl/tomasulo_rs_gen.sv
// N-entry reservation station: CDB operand wake-up, oldest-ready issue chosen by an age matrix.
// Optional flush port is compiled in with `define TOMASULO_RS_FLUSH_EN.
module tomasulo_rs_gen #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TAG_W   = 5,
  parameter int ROBID_W = 5,
  parameter int OP_W    = 4,
  parameter int WA_W    = 5,
  parameter int IMM_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_vld,
  output logic                     disp_rdy,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [ROBID_W-1:0]       disp_robid,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [WA_W-1:0]          disp_wa,
  input  logic [1:0]               disp_busy,
  input  logic [2*W-1:0]           disp_val,
  input  logic                     cdb_vld,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [W-1:0]             cdb_wdata,
  output logic                     iss_vld,
  input  logic                     iss_rdy,
  output logic [OP_W-1:0]          iss_op,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [ROBID_W-1:0]       iss_robid,
  output logic [IMM_W-1:0]         iss_imm,
  output logic [WA_W-1:0]          iss_wa,
  output logic [2*W-1:0]           iss_rdata,
  output logic [$clog2(N+1)-1:0]   occupancy
`ifdef TOMASULO_RS_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int OCC_W = $clog2(N + 1);

  logic [N-1:0]                       valid_q, valid_d;
  logic [N-1:0][N-1:0]                age_q, age_d;
  logic [OCC_W-1:0]                   occ_q, occ_d;
  logic [N-1:0][1:0]                  busy_q, busy_d;
  logic [N-1:0][1:0][W-1:0]           val_q, val_d;
  logic [N-1:0][OP_W-1:0]             op_q, op_d;
  logic [N-1:0][TAG_W-1:0]            tag_q, tag_d;
  logic [N-1:0][ROBID_W-1:0]          robid_q, robid_d;
  logic [N-1:0][IMM_W-1:0]            imm_q, imm_d;
  logic [N-1:0][WA_W-1:0]             wa_q, wa_d;

  logic             flush_w;
  logic [N-1:0]     ready;
  logic             sel_found, free_found;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             older_rdy;
  logic             disp_fire, iss_fire;

`ifdef TOMASULO_RS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Oldest ready entry: ready and no other ready entry has its age bit set against it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ready      = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    older_rdy  = 1'b0;
    for (int i = 0; i < N; i++) ready[i] = valid_q[i] & ~(|busy_q[i]);
    for (int i = 0; i < N; i++) begin
      older_rdy = 1'b0;
      for (int j = 0; j < N; j++) if (ready[j] && age_q[j][i]) older_rdy = 1'b1;
      if (ready[i] && !older_rdy && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_rdy  = (occ_q != OCC_W'(N));
  assign iss_vld   = sel_found & ~flush_w;
  assign disp_fire = disp_vld & disp_rdy & ~flush_w;
  assign iss_fire  = iss_vld & iss_rdy;
  assign occupancy = occ_q;

  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    busy_d  = busy_q;
    val_d   = val_q;
    op_d    = op_q;
    tag_d   = tag_q;
    robid_d = robid_q;
    imm_d   = imm_q;
    wa_d    = wa_q;
    occ_d   = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        if (valid_q[i] && busy_q[i][k] && cdb_vld && val_q[i][k][TAG_W-1:0] == cdb_tag) begin
          busy_d[i][k] = 1'b0;
          val_d[i][k]  = cdb_wdata;
        end

    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = disp_op;
      tag_d[free_idx]   = disp_tag;
      robid_d[free_idx] = disp_robid;
      imm_d[free_idx]   = disp_imm;
      wa_d[free_idx]    = disp_wa;
      // A broadcast in the dispatch cycle must be captured here or that wake-up is lost.
      for (int k = 0; k < 2; k++) begin
        val_d[free_idx][k]  = disp_val[k*W +: W];
        busy_d[free_idx][k] = disp_busy[k];
        if (disp_busy[k] && cdb_vld && disp_val[k*W +: TAG_W] == cdb_tag) begin
          val_d[free_idx][k]  = cdb_wdata;
          busy_d[free_idx][k] = 1'b0;
        end
      end
      for (int j = 0; j < N; j++) begin
        age_d[free_idx][j] = 1'b0;
        age_d[j][free_idx] = valid_q[j];
      end
    end

    if (iss_fire) begin
      valid_d[sel_idx] = 1'b0;
      for (int j = 0; j < N; j++) begin
        age_d[sel_idx][j] = 1'b0;
        age_d[j][sel_idx] = 1'b0;
      end
    end

    if (flush_w) begin
      valid_d = '0;
      age_d   = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      age_q   <= '0;
      occ_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      age_q   <= age_d;
      occ_q   <= occ_d;
    end
  end

  // NOTE: entry payload is not reset; it is only observed through a valid bit, which is.
  always_ff @(posedge clk) begin
    busy_q  <= busy_d;
    val_q   <= val_d;
    op_q    <= op_d;
    tag_q   <= tag_d;
    robid_q <= robid_d;
    imm_q   <= imm_d;
    wa_q    <= wa_d;
  end

  always_comb begin
    iss_op    = '0;
    iss_tag   = '0;
    iss_robid = '0;
    iss_imm   = '0;
    iss_wa    = '0;
    iss_rdata = '0;
    if (iss_vld) begin
      iss_op    = op_q[sel_idx];
      iss_tag   = tag_q[sel_idx];
      iss_robid = robid_q[sel_idx];
      iss_imm   = imm_q[sel_idx];
      iss_wa    = wa_q[sel_idx];
      iss_rdata = {val_q[sel_idx][1], val_q[sel_idx][0]};
    end
  end

endmodule

// File: tb/tb_tomasulo_rs_gen.sv
// Directed self-checking bench for tomasulo_rs_gen at N=4, W=32.
// Flush scenario is compiled in only with TOMASULO_RS_FLUSH_EN.
module tb_tomasulo_rs_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_vld;
  logic        disp_rdy;
  logic [3:0]  disp_op;
  logic [4:0]  disp_tag;
  logic [4:0]  disp_robid;
  logic [31:0] disp_imm;
  logic [4:0]  disp_wa;
  logic [1:0]  disp_busy;
  logic [63:0] disp_val;
  logic        cdb_vld;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic        iss_vld;
  logic        iss_rdy;
  logic [3:0]  iss_op;
  logic [4:0]  iss_tag;
  logic [4:0]  iss_robid;
  logic [31:0] iss_imm;
  logic [4:0]  iss_wa;
  logic [63:0] iss_rdata;
  logic [2:0]  occupancy;
`ifdef TOMASULO_RS_FLUSH_EN
  logic        flush;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  tomasulo_rs_gen #(.N(4), .W(32), .TAG_W(5), .ROBID_W(5), .OP_W(4), .WA_W(5), .IMM_W(32)) dut (
    .clk(clk), .rst(rst),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy),
    .disp_op(disp_op), .disp_tag(disp_tag), .disp_robid(disp_robid),
    .disp_imm(disp_imm), .disp_wa(disp_wa),
    .disp_busy(disp_busy), .disp_val(disp_val),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .iss_vld(iss_vld), .iss_rdy(iss_rdy),
    .iss_op(iss_op), .iss_tag(iss_tag), .iss_robid(iss_robid),
    .iss_imm(iss_imm), .iss_wa(iss_wa), .iss_rdata(iss_rdata),
    .occupancy(occupancy)
`ifdef TOMASULO_RS_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_vld   = 1'b0;
    disp_op    = '0;
    disp_tag   = '0;
    disp_robid = '0;
    disp_imm   = '0;
    disp_wa    = '0;
    disp_busy  = '0;
    disp_val   = '0;
    cdb_vld    = 1'b0;
    cdb_tag    = '0;
    cdb_wdata  = '0;
    iss_rdy    = 1'b0;
`ifdef TOMASULO_RS_FLUSH_EN
    flush      = 1'b0;
`endif
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [4:0] robid, input logic [1:0] busy,
                          input logic [31:0] v1, input logic [31:0] v0);
    disp_vld   = 1'b1;
    disp_op    = op;
    disp_tag   = robid;
    disp_robid = robid;
    disp_imm   = 32'h100 + 32'(robid);
    disp_wa    = robid;
    disp_busy  = busy;
    disp_val   = {v1, v0};
  endtask

  task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data);
    cdb_vld   = 1'b1;
    cdb_tag   = tag;
    cdb_wdata = data;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    check("rst_disp_rdy", 64'(disp_rdy), 64'd1);
    check("rst_iss_vld", 64'(iss_vld), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_rdata", iss_rdata, 64'd0);
    rst = 1'b0;
    tick();

    // Ready ADD 3,5: visible one cycle after dispatch, freed on handshake
    set_disp(4'd1, 5'd3, 2'b00, 32'd5, 32'd3);
    check("add_no_same_cycle", 64'(iss_vld), 64'd0);
    tick();
    idle();
    check("add_iss_vld", 64'(iss_vld), 64'd1);
    check("add_rdata", iss_rdata, {32'd5, 32'd3});
    check("add_op", 64'(iss_op), 64'd1);
    check("add_robid", 64'(iss_robid), 64'd3);
    check("add_imm", 64'(iss_imm), 64'h103);
    check("add_occ1", 64'(occupancy), 64'd1);
    iss_rdy = 1'b1;
    tick();
    idle();
    check("add_occ0", 64'(occupancy), 64'd0);
    check("add_iss_drop", 64'(iss_vld), 64'd0);

    // Operand 0 waits on tag 7; a non-matching broadcast must not wake it
    set_disp(4'd2, 5'd4, 2'b01, 32'd11, 32'd7);
    tick();
    idle();
    check("wake_wait", 64'(iss_vld), 64'd0);
    set_cdb(5'd6, 32'hBAD);
    tick();
    idle();
    check("wake_wrong_tag", 64'(iss_vld), 64'd0);
    set_cdb(5'd7, 32'hDEAD);
    check("wake_no_bypass", 64'(iss_vld), 64'd0);
    tick();
    idle();
    check("wake_iss_vld", 64'(iss_vld), 64'd1);
    check("wake_rdata", iss_rdata, {32'd11, 32'hDEAD});
    iss_rdy = 1'b1;
    tick();
    idle();
    check("wake_occ0", 64'(occupancy), 64'd0);

    // Same-cycle capture of a broadcast during dispatch
    set_disp(4'd3, 5'd5, 2'b10, 32'd9, 32'd20);
    set_cdb(5'd9, 32'h42);
    tick();
    idle();
    check("cap_iss_vld", 64'(iss_vld), 64'd1);
    check("cap_rdata", iss_rdata, {32'h42, 32'd20});
    iss_rdy = 1'b1;
    tick();
    idle();
    check("cap_occ0", 64'(occupancy), 64'd0);

    // Fill, then issue while dispatch is held at full
    for (int k = 0; k < 4; k++) begin
      set_disp(4'd1, 5'(k), 2'b00, 32'(k + 40), 32'(k + 30));
      tick();
    end
    idle();
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_disp_rdy", 64'(disp_rdy), 64'd0);
    check("full_oldest", 64'(iss_robid), 64'd0);
    set_disp(4'd1, 5'd4, 2'b00, 32'd44, 32'd34);
    iss_rdy = 1'b1;
    tick();
    check("full_refused_occ", 64'(occupancy), 64'd3);
    check("full_rdy_again", 64'(disp_rdy), 64'd1);
    iss_rdy = 1'b0;
    tick();
    idle();
    check("full_accept_occ", 64'(occupancy), 64'd4);
    iss_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_robid%0d", k), 64'(iss_robid), 64'(k));
      check($sformatf("drain_rdata%0d", k), iss_rdata, {32'(k + 40), 32'(k + 30)});
      tick();
    end
    idle();
    check("drain_occ0", 64'(occupancy), 64'd0);

    // Older A waits on tag 2, younger B ready
    set_disp(4'd4, 5'd10, 2'b01, 32'd1, 32'd2);
    tick();
    set_disp(4'd5, 5'd11, 2'b00, 32'd66, 32'd55);
    tick();
    idle();
    check("age_b_first", 64'(iss_robid), 64'd11);
    set_cdb(5'd2, 32'h77);
    check("age_b_during_wake", 64'(iss_robid), 64'd11);
    tick();
    idle();
    check("age_a_oldest", 64'(iss_robid), 64'd10);
    check("age_a_rdata", iss_rdata, {32'd1, 32'h77});
    iss_rdy = 1'b1;
    tick();
    check("age_b_next", 64'(iss_robid), 64'd11);
    check("age_b_rdata", iss_rdata, {32'd66, 32'd55});
    tick();
    idle();
    check("age_occ0", 64'(occupancy), 64'd0);

    // One broadcast wakes two entries on different operands
    set_disp(4'd6, 5'd20, 2'b01, 32'd8, 32'd5);
    tick();
    set_disp(4'd6, 5'd21, 2'b10, 32'd5, 32'd9);
    tick();
    idle();
    set_cdb(5'd5, 32'h55);
    tick();
    idle();
    iss_rdy = 1'b1;
    check("multi_c_robid", 64'(iss_robid), 64'd20);
    check("multi_c_rdata", iss_rdata, {32'd8, 32'h55});
    tick();
    check("multi_d_robid", 64'(iss_robid), 64'd21);
    check("multi_d_rdata", iss_rdata, {32'h55, 32'd9});
    tick();
    idle();
    check("multi_occ0", 64'(occupancy), 64'd0);

    // Asynchronous reset mid-operation
    set_disp(4'd1, 5'd1, 2'b00, 32'd1, 32'd1);
    tick();
    idle();
    check("arst_pre_vld", 64'(iss_vld), 64'd1);
    rst = 1'b1;
    #2;
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_iss_vld", 64'(iss_vld), 64'd0);
    check("arst_rdata", iss_rdata, 64'd0);
    rst = 1'b0;
    tick();

`ifdef TOMASULO_RS_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      set_disp(4'd1, 5'(k), 2'b00, 32'd1, 32'd2);
      tick();
    end
    idle();
    check("flush_pre_occ", 64'(occupancy), 64'd3);
    flush = 1'b1;
    set_disp(4'd1, 5'd7, 2'b00, 32'd1, 32'd2);
    check("flush_iss_vld", 64'(iss_vld), 64'd0);
    tick();
    idle();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_disp_rdy", 64'(disp_rdy), 64'd1);
    check("flush_empty", 64'(iss_vld), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tomasulo_rs_gen.md
# tomasulo_rs_gen

Parametrised reservation station for the Tomasulo pipeline, generalising the fixed four-entry station to N entries with configurable word, tag and ROB-id widths. Accepts dispatched instructions whose operands are either captured values or pending tags, snoops the common data bus (CDB) to wake operands, and issues the oldest ready entry to its functional unit over a valid/ready handshake. It sits between the dispatch stage and one execution unit (arith, logic or mpy).

## Interface
- N, 4: number of entries (2..16)
- W, 32: operand/result word width
- TAG_W, 5: producer tag width (TAG_W <= W)
- ROBID_W, 5: ROB index width
- OP_W, 4: opcode width
- WA_W, 5: write-address width
- IMM_W, 32: immediate width

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- disp_vld  in  1  dispatch request
- disp_rdy  out  1  station can accept
- disp_op / disp_tag / disp_robid / disp_imm / disp_wa  in  OP_W / TAG_W / ROBID_W / IMM_W / WA_W  instruction fields
- disp_busy  in  2  per-operand pending flag
- disp_val  in  2*W  per-operand value, or tag in low TAG_W bits when busy
- cdb_vld  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast producer tag
- cdb_wdata  in  W  broadcast result
- iss_vld  out  1  an entry is ready to issue
- iss_rdy  in  1  functional unit accepts
- iss_op / iss_tag / iss_robid / iss_imm / iss_wa  out  as dispatch  issued fields
- iss_rdata  out  2*W  issued operand values
- occupancy  out  $clog2(N+1)  valid entry count
- flush  in  1  only with TOMASULO_RS_FLUSH_EN

## Operation
- Entry state: valid, fields, per-operand busy + value/tag. Age tracked with an NxN age matrix (row i bit j set = i older than j).
- Dispatch fires on disp_vld & disp_rdy; writes lowest-index free entry; new entry marked younger than all valid entries.
- Same-cycle capture: if a dispatched operand is busy and cdb_vld with cdb_tag equal to its tag, store cdb_wdata and clear busy. Mandatory (otherwise the wake-up is lost).
- Wake-up: each valid, busy operand whose stored tag matches cdb_tag when cdb_vld captures cdb_wdata, clears busy. Multiple operands/entries may wake on one broadcast.
- Ready = valid & both operands not busy, evaluated on registered state.
- Select: oldest ready entry via age matrix; fields driven combinationally to iss_*. When iss_vld=0 all iss_* data outputs are zero.
- Entry freed on iss_vld & iss_rdy; its age row/column cleared.
- disp_rdy = (occupancy != N); freed slot not reusable in the same cycle.
- occupancy += dispatch fire, -= issue fire; both together leave it unchanged.

## Timing
- Reset: all entries invalid, age matrix zero, occupancy 0, disp_rdy 1, iss_vld 0, iss_* 0.
- Dispatch with ready operands at cycle t: iss_vld earliest at t+1.
- CDB wake at cycle t: entry eligible at t+1 (no CDB-to-issue bypass).
- iss_vld may drop or switch entry while iss_rdy=0 if an older entry becomes ready; issue is committed only on handshake.
- Full with simultaneous issue: dispatch refused that cycle, disp_rdy=1 next cycle.
- Reset asserted mid-operation: all state cleared immediately, outputs to reset values without waiting for clk.

## Configuration
- TOMASULO_RS_FLUSH_EN defined: flush port exists; flush high at cycle t invalidates all entries at t+1, ignores dispatch at t, forces iss_vld=0 at t, occupancy 0 at t+1.
- Not defined: no flush port; entries leave only by issue.

## Test plan
- Reset, dispatch ADD with operands 3 and 5 ready -> iss_vld next cycle, iss_rdata={5,3}, entry freed on iss_rdy, occupancy 1->0.
- Dispatch op0 busy tag 7, then cdb_vld tag 7 data 0xDEAD -> iss_vld one cycle after broadcast with iss_rdata[0]=0xDEAD.
- Dispatch busy tag 9 while cdb broadcasts tag 9 data 0x42 same cycle -> captured, issues next cycle with 0x42.
- N=4: fill four entries, iss_rdy=0 -> disp_rdy=0 at occupancy 4; issue one with dispatch held -> dispatch accepted next cycle.
- Entries A (older, waiting tag 2) and B (younger, ready); wake A -> B issues first only if selected before wake; with both ready, A issues first.
- With TOMASULO_RS_FLUSH_EN: three valid entries, flush=1 -> iss_vld=0 that cycle, occupancy 0 and disp_rdy=1 next cycle.
